// File: rtl/ip_stride_pkg.sv
// Shared types for the IP-indexed stride prefetcher: table entry layout and
// issue FSM states. Entry fields are held at the widest supported sizes so one
// struct serves every parameterisation; the top uses the low bits it needs.
package ip_stride_pkg;

    localparam int MAX_ADDR_W = 64;
    localparam int MAX_TAG_W  = 64;
    localparam int MAX_CONF_W = 8;

    typedef struct packed {
        logic                         valid;
        logic [MAX_TAG_W-1:0]         tag;
        logic [MAX_ADDR_W-1:0]        last_addr;
        logic signed [MAX_ADDR_W-1:0] stride;
        logic [MAX_CONF_W-1:0]        conf;
    } entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_e;

endpackage

// File: rtl/ip_stride_queue_fifo.sv
// First-word-fall-through FIFO for prefetch candidates. A push into a full
// FIFO is still accepted when a pop happens in the same cycle.
module pref_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Occupancy flags from the extra wrap bit, and the effective push/pop.
    always_comb begin
        valid     = (r_wr_ptr != r_rd_ptr);
        full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
        w_do_pop  = pop & valid;
        w_do_push = push & (~full | w_do_pop);
        data      = valid ? r_mem[r_rd_ptr[PTR_W-1:0]] : '0;
    end

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ip_stride_queue.sv
// IP-indexed stride prefetcher: trains a per-IP stride table on demand
// accesses and bursts up to DEGREE same-page candidates into an output FIFO.
module ip_stride_queue
    import ip_stride_pkg::*;
#(
    parameter int TRACKERS    = 64,
    parameter int DEGREE      = 3,
    parameter int ADDR_W      = 64,
    parameter int IP_W        = 64,
    parameter int CONF_W      = 2,
    parameter int CONF_THRESH = 2,
    parameter int PAGE_BITS   = 12,
    parameter int QDEPTH      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              access_valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [IP_W-1:0]   ip_i,
    output logic              pref_valid_o,
    input  logic              pref_ready_i,
    output logic [ADDR_W-1:0] pref_addr_o,
    output logic [15:0]       drop_cnt_o
);

    localparam int IDX_W = $clog2(TRACKERS);
    localparam int TAG_W = IP_W - IDX_W;
    localparam logic [MAX_CONF_W-1:0] CONF_MAX = MAX_CONF_W'((1 << CONF_W) - 1);
    localparam logic [MAX_CONF_W-1:0] CONF_TH  = MAX_CONF_W'(CONF_THRESH);
    localparam logic [3:0]            DEG      = 4'(DEGREE);

    // Training table
    entry_t                r_table [TRACKERS];
    logic [TRACKERS-1:0]   r_valid;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    entry_t                w_ent;
    entry_t                w_new;
    logic                  w_hit;
    logic [ADDR_W-1:0]     w_last;
    logic [ADDR_W-1:0]     w_stride_old;
    logic [ADDR_W-1:0]     w_delta;
    logic [ADDR_W-1:0]     w_stride_new;
    logic [MAX_CONF_W-1:0] w_conf_new;
    logic                  w_match;
    logic                  w_trigger;

    // Issue FSM
    issue_state_e          r_state, w_state_next;
    logic [ADDR_W-1:0]     r_base, w_base_next;
    logic [ADDR_W-1:0]     r_stride, w_stride_next;
    logic [ADDR_W-1:0]     r_cand, w_cand_next;
    logic [3:0]            r_k, w_k_next;
    logic                  w_same_page;
    logic                  w_push;

    // Output side
    logic                  w_full;
    logic                  w_pop;
    logic [15:0]           r_drop_cnt;

    // Lookup, delta/confidence computation and trigger decision.
    always_comb begin
        w_idx        = ip_i[IDX_W-1:0];
        w_tag        = ip_i[IP_W-1:IDX_W];
        w_ent        = r_table[w_idx];
        w_hit        = r_valid[w_idx] && w_ent.valid &&
                       (w_ent.tag == MAX_TAG_W'(w_tag));
        w_last       = w_ent.last_addr[ADDR_W-1:0];
        w_stride_old = w_ent.stride[ADDR_W-1:0];
        w_delta      = addr_i - w_last;
        w_match      = (w_delta == w_stride_old) && (w_delta != '0);
        w_stride_new = w_match ? w_stride_old : w_delta;
        if (!w_match) begin
            w_conf_new = '0;
        end else if (w_ent.conf >= CONF_MAX) begin
            w_conf_new = CONF_MAX;
        end else begin
            w_conf_new = w_ent.conf + 1'b1;
        end
        // A non-matching hit resets conf to 0, so only matching hits can fire.
        w_trigger    = access_valid_i && w_hit && w_match && (w_conf_new >= CONF_TH);

        w_new.valid     = 1'b1;
        w_new.tag       = MAX_TAG_W'(w_tag);
        w_new.last_addr = MAX_ADDR_W'(addr_i);
        w_new.stride    = w_hit ? MAX_ADDR_W'(w_stride_new) : '0;
        w_new.conf      = w_hit ? w_conf_new : '0;
    end

    // Table data fields; a miss and a hit both rewrite the whole entry.
    always_ff @(posedge clk) begin
        if (access_valid_i) begin
            r_table[w_idx] <= w_new;
        end
    end

    // Table valid bits, the only table state cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (access_valid_i) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    // Issue FSM next state: walk candidates, stop on page cross, reload on trigger.
    always_comb begin
        w_state_next  = r_state;
        w_base_next   = r_base;
        w_stride_next = r_stride;
        w_cand_next   = r_cand;
        w_k_next      = r_k;
        w_push        = 1'b0;
        w_same_page   = (r_cand[ADDR_W-1:PAGE_BITS] == r_base[ADDR_W-1:PAGE_BITS]);

        if (r_state == ISSUE) begin
            if (!w_same_page) begin
                w_state_next = IDLE;
            end else begin
                w_push = 1'b1;
                if (r_k == DEG) begin
                    w_state_next = IDLE;
                end else begin
                    w_k_next    = r_k + 1'b1;
                    w_cand_next = r_cand + r_stride;
                end
            end
        end

        // A fresh trigger always wins over the remainder of a running burst.
        if (w_trigger) begin
            w_state_next  = ISSUE;
            w_base_next   = addr_i;
            w_stride_next = w_stride_new;
            w_cand_next   = addr_i + w_stride_new;
            w_k_next      = 4'd1;
        end
    end

    // Issue FSM registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_stride <= '0;
            r_cand   <= '0;
            r_k      <= 4'd1;
        end else begin
            r_state  <= w_state_next;
            r_base   <= w_base_next;
            r_stride <= w_stride_next;
            r_cand   <= w_cand_next;
            r_k      <= w_k_next;
        end
    end

    assign w_pop = pref_valid_o & pref_ready_i;

    pref_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (r_cand),
        .full      (w_full),
        .pop       (w_pop),
        .valid     (pref_valid_o),
        .data      (pref_addr_o)
    );

    // Saturating count of candidates lost because the FIFO stayed full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_push && w_full && !w_pop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_ip_stride_queue.sv
// Self-checking bench for ip_stride_queue: default instance with a scoreboard
// monitor, plus a QDEPTH=4 instance for the overflow/drop scenario.
module tb_ip_stride_queue;

    logic        clk = 1'b0;
    logic        rst;

    logic        access_valid, ready, pv;
    logic [63:0] addr, ip, pa;
    logic [15:0] drop;

    logic        access_valid4, ready4, pv4;
    logic [63:0] addr4, ip4, pa4;
    logic [15:0] drop4;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q  [$];
    logic [63:0] exp4_q [$];

    always #5 clk = ~clk;

    ip_stride_queue dut (
        .clk            (clk),
        .rst            (rst),
        .access_valid_i (access_valid),
        .addr_i         (addr),
        .ip_i           (ip),
        .pref_valid_o   (pv),
        .pref_ready_i   (ready),
        .pref_addr_o    (pa),
        .drop_cnt_o     (drop)
    );

    ip_stride_queue #(.QDEPTH(4)) dut4 (
        .clk            (clk),
        .rst            (rst),
        .access_valid_i (access_valid4),
        .addr_i         (addr4),
        .ip_i           (ip4),
        .pref_valid_o   (pv4),
        .pref_ready_i   (ready4),
        .pref_addr_o    (pa4),
        .drop_cnt_o     (drop4)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_access(input logic [63:0] ipv, input logic [63:0] av);
        access_valid = 1'b1;
        ip           = ipv;
        addr         = av;
        @(posedge clk);
        #1;
        access_valid = 1'b0;
        $display("access ip=%0d addr=%h", ipv, av);
    endtask

    task automatic do_access4(input logic [63:0] ipv, input logic [63:0] av);
        access_valid4 = 1'b1;
        ip4           = ipv;
        addr4         = av;
        @(posedge clk);
        #1;
        access_valid4 = 1'b0;
        $display("access4 ip=%0d addr=%h", ipv, av);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_val({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, "_idle"}, {63'd0, pv}, 64'd0);
    endtask

    // Scoreboard: every accepted head must match the oldest expected address.
    always @(negedge clk) begin
        if (!rst && pv && ready) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_valid", {63'd0, pv}, 64'd0);
            end else begin
                check_val("pref_addr", pa, exp_q.pop_front());
                $display("pop addr=%h", pa);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        access_valid = 1'b0; addr = '0; ip = '0; ready = 1'b1;
        access_valid4 = 1'b0; addr4 = '0; ip4 = '0; ready4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", {63'd0, pv}, 64'd0);
        check_val("rst_addr", pa, 64'd0);
        check_val("rst_drop", {48'd0, drop}, 64'd0);
        check_val("rst_valid4", {63'd0, pv4}, 64'd0);
        rst = 1'b0;

        // Basic positive stride, with 1-cycle latency from the trigger edge
        for (int i = 0; i < 3; i++) begin
            do_access(64'd5, 64'h1000 + 64'(i) * 64'h40);
            check_val("train_novalid", {63'd0, pv}, 64'd0);
        end
        exp_q.push_back(64'h1100);
        exp_q.push_back(64'h1140);
        exp_q.push_back(64'h1180);
        do_access(64'd5, 64'h10C0);
        check_val("lat_e0", {63'd0, pv}, 64'd0);
        @(posedge clk);
        #1;
        check_val("lat_e1_valid", {63'd0, pv}, 64'd1);
        check_val("lat_e1_addr", pa, 64'h1100);
        wait_drain("pos");

        // Page-boundary suppression
        exp_q.push_back(64'h1FC0);
        do_access(64'd7, 64'h1EC0);
        do_access(64'd7, 64'h1F00);
        do_access(64'd7, 64'h1F40);
        do_access(64'd7, 64'h1F80);
        wait_drain("page");
        check_val("page_drop", {48'd0, drop}, 64'd0);

        // Negative stride
        exp_q.push_back(64'h2F00);
        exp_q.push_back(64'h2EC0);
        exp_q.push_back(64'h2E80);
        do_access(64'd9, 64'h3000);
        do_access(64'd9, 64'h2FC0);
        do_access(64'd9, 64'h2F80);
        do_access(64'd9, 64'h2F40);
        wait_drain("neg");

        // Aliasing IPs on the same index never build confidence
        for (int i = 0; i < 8; i++) begin
            do_access((i % 2 == 0) ? 64'd69 : 64'd5, 64'h5000 + 64'(i) * 64'h40);
            check_val("alias_novalid", {63'd0, pv}, 64'd0);
        end
        wait_drain("alias");

        // Reset one cycle into a burst
        do_access(64'd11, 64'h4000);
        do_access(64'd11, 64'h4040);
        do_access(64'd11, 64'h4080);
        do_access(64'd11, 64'h40C0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("midrst_valid", {63'd0, pv}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            do_access(64'd11, 64'h4100 + 64'(i) * 64'h40);
            check_val("postrst_novalid", {63'd0, pv}, 64'd0);
        end
        exp_q.push_back(64'h4200);
        exp_q.push_back(64'h4240);
        exp_q.push_back(64'h4280);
        do_access(64'd11, 64'h41C0);
        check_val("postrst_e0", {63'd0, pv}, 64'd0);
        wait_drain("rst");

        // Overflow on the QDEPTH=4 instance
        exp4_q.push_back(64'h8100);
        exp4_q.push_back(64'h8140);
        exp4_q.push_back(64'h8180);
        exp4_q.push_back(64'h9100);
        for (int i = 0; i < 4; i++) do_access4(64'd1, 64'h8000 + 64'(i) * 64'h40);
        for (int i = 0; i < 4; i++) do_access4(64'd2, 64'h9000 + 64'(i) * 64'h40);
        repeat (4) @(posedge clk);
        #1;
        check_val("ovf_drop", {48'd0, drop4}, 64'd2);
        check_val("ovf_valid", {63'd0, pv4}, 64'd1);
        @(posedge clk);
        #1;
        check_val("ovf_hold_addr", pa4, 64'h8100);
        ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("ovf_drain_valid", {63'd0, pv4}, 64'd1);
            if (exp4_q.size() != 0) begin
                check_val("ovf_drain_addr", pa4, exp4_q.pop_front());
            end
            $display("pop4 addr=%h", pa4);
        end
        @(posedge clk);
        #1;
        check_val("ovf_empty", {63'd0, pv4}, 64'd0);
        check_val("ovf_drop_final", {48'd0, drop4}, 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
